// File: rtl/chacha_block_engine.sv
// chacha_block_engine - ChaCha block function core.
// Builds the 4x4 ChaCha state from key/nonce/counter, runs ROUNDS rounds with
// QR_LANES quarter-rounds in flight (one ARX step per lane per cycle), adds the
// original state back in and presents the 512-bit block on a valid/ready port.
// Optional feature: define CHACHA_MULTIBLOCK_EN to add the num_blocks port so
// one request emits several blocks with consecutive counters.
module chacha_block_engine #(
    parameter int ROUNDS   = 20,
    parameter int QR_LANES = 1,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [255:0]       key,
    input  logic [95:0]        nonce,
    input  logic [31:0]        counter_init,
`ifdef CHACHA_MULTIBLOCK_EN
    input  logic [COUNT_W-1:0] num_blocks,
`endif
    output logic               block_valid,
    input  logic               block_ready,
    output logic [511:0]       block_out,
    output logic [COUNT_W-1:0] block_count,
    output logic               busy,
    output logic               ctr_wrap
);

    if ((ROUNDS <= 32'sd0) || ((ROUNDS % 32'sd2) != 32'sd0)) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be even and greater than zero");
    end
    if ((QR_LANES != 32'sd1) && (QR_LANES != 32'sd2) && (QR_LANES != 32'sd4)) begin : g_bad_lanes
        $error("chacha_block_engine: QR_LANES must be 1, 2 or 4");
    end

    localparam int SLOTS  = (QR_LANES > 32'sd0) ? (32'sd4 / QR_LANES) : 32'sd1;
    localparam int PAIRS  = ROUNDS / 32'sd2;
    localparam int PAIR_W = (PAIRS > 32'sd1) ? $clog2(PAIRS + 32'sd1) : 32'sd1;
    localparam logic [1:0]         SLOT_LAST = 2'(SLOTS - 32'sd1);
    localparam logic [PAIR_W-1:0]  PAIR_LAST = PAIR_W'(PAIRS - 32'sd1);
    localparam logic [PAIR_W-1:0]  PAIR_ONE  = PAIR_W'(1'b1);
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1'b1);
    // "expand 32-byte k" constants, word 0 in the low bits
    localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    typedef enum logic [2:0] {IDLE, LOAD, COL, DIAG, FEED, OUT} state_t;

    state_t              state_r, state_next_s;
    logic [255:0]        key_r;
    logic [95:0]         nonce_r;
    logic [31:0]         counter_r;
    logic [COUNT_W-1:0]  blocks_left_r, block_count_r;
    logic                ctr_wrap_r, block_valid_r;
    logic [15:0][31:0]   work_r, orig_r, work_next_s, init_s, block_out_r;
    logic [1:0]          step_r, slot_r;
    logic [PAIR_W-1:0]   pair_r;
    logic                phase_end_s, pair_last_s, last_block_s;
    logic [1:0]          qc_s;
    logic                diag_s;
    logic [3:0]          ia_s, ib_s, ic_s, id_s;
    logic [127:0]        arx_s;
    logic [COUNT_W-1:0]  req_blocks_s;

    // One ARX step of a quarter-round; returns {a, b, c, d}.
    function automatic logic [127:0] arx_step(input logic [31:0] a_in, input logic [31:0] b_in,
                                              input logic [31:0] c_in, input logic [31:0] d_in,
                                              input logic [1:0]  step);
        logic [31:0] a, b, c, d, t;
        a = a_in; b = b_in; c = c_in; d = d_in;
        case (step)
            2'd0:    begin a = a + b; t = d ^ a; d = {t[15:0], t[31:16]}; end
            2'd1:    begin c = c + d; t = b ^ c; b = {t[19:0], t[31:20]}; end
            2'd2:    begin a = a + b; t = d ^ a; d = {t[23:0], t[31:24]}; end
            2'd3:    begin c = c + d; t = b ^ c; b = {t[24:0], t[31:25]}; end
            default: begin t = 32'h0000_0000; end
        endcase
        return {a, b, c, d};
    endfunction

    assign init_s       = {nonce_r, counter_r, key_r, SIGMA};
    assign phase_end_s  = (step_r == 2'd3) && (slot_r == SLOT_LAST);
    assign pair_last_s  = (pair_r == PAIR_LAST);
    assign last_block_s = (blocks_left_r <= CNT_ONE);
`ifdef CHACHA_MULTIBLOCK_EN
    assign req_blocks_s = (num_blocks == {COUNT_W{1'b0}}) ? CNT_ONE : num_blocks;
`else
    assign req_blocks_s = CNT_ONE;
`endif

    assign start_ready = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign block_valid = block_valid_r;
    assign block_out   = block_out_r;
    assign block_count = block_count_r;
    assign ctr_wrap    = ctr_wrap_r;

    // Next working state: every lane applies the current ARX step to its quarter-round.
    always_comb begin
        work_next_s = work_r;
        diag_s      = (state_r == DIAG);
        qc_s        = 2'd0;
        ia_s        = 4'd0;
        ib_s        = 4'd0;
        ic_s        = 4'd0;
        id_s        = 4'd0;
        arx_s       = 128'd0;
        for (int l = 0; l < QR_LANES; l++) begin
            qc_s  = 2'(int'(slot_r) * QR_LANES + l);
            // Diagonal QR q uses column q+r (mod 4) in row r
            ia_s  = {2'b00, qc_s};
            ib_s  = {2'b01, diag_s ? (qc_s + 2'd1) : qc_s};
            ic_s  = {2'b10, diag_s ? (qc_s + 2'd2) : qc_s};
            id_s  = {2'b11, diag_s ? (qc_s + 2'd3) : qc_s};
            arx_s = arx_step(work_r[ia_s], work_r[ib_s], work_r[ic_s], work_r[id_s], step_r);
            work_next_s[ia_s] = arx_s[127:96];
            work_next_s[ib_s] = arx_s[95:64];
            work_next_s[ic_s] = arx_s[63:32];
            work_next_s[id_s] = arx_s[31:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (start_valid) state_next_s = LOAD; else state_next_s = IDLE;
            LOAD:    state_next_s = COL;
            COL:     if (phase_end_s) state_next_s = DIAG; else state_next_s = COL;
            DIAG: begin
                if (phase_end_s) state_next_s = pair_last_s ? FEED : COL;
                else             state_next_s = DIAG;
            end
            FEED:    state_next_s = OUT;
            OUT: begin
                if (block_ready) state_next_s = last_block_s ? IDLE : LOAD;
                else             state_next_s = OUT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: request capture, round sequencing, feed-forward and hand-off bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r         <= '0;
            nonce_r       <= '0;
            counter_r     <= '0;
            blocks_left_r <= '0;
            block_count_r <= '0;
            ctr_wrap_r    <= 1'b0;
            block_valid_r <= 1'b0;
            work_r        <= '0;
            orig_r        <= '0;
            block_out_r   <= '0;
            step_r        <= 2'd0;
            slot_r        <= 2'd0;
            pair_r        <= '0;
        end else begin
            block_valid_r <= (state_next_s == OUT);
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        key_r         <= key;
                        nonce_r       <= nonce;
                        counter_r     <= counter_init;
                        blocks_left_r <= req_blocks_s;
                        block_count_r <= '0;
                        ctr_wrap_r    <= 1'b0;
                    end
                end
                LOAD: begin
                    work_r <= init_s;
                    orig_r <= init_s;
                    step_r <= 2'd0;
                    slot_r <= 2'd0;
                    pair_r <= '0;
                end
                COL, DIAG: begin
                    work_r <= work_next_s;
                    step_r <= step_r + 2'd1;
                    if (step_r == 2'd3) begin
                        slot_r <= (slot_r == SLOT_LAST) ? 2'd0 : (slot_r + 2'd1);
                    end
                    if (phase_end_s && (state_r == DIAG)) begin
                        pair_r <= pair_r + PAIR_ONE;
                    end
                end
                FEED: begin
                    for (int i = 0; i < 16; i++) begin
                        block_out_r[i] <= work_r[i] + orig_r[i];
                    end
                end
                OUT: begin
                    if (block_ready) begin
                        block_count_r <= block_count_r + CNT_ONE;
                        blocks_left_r <= blocks_left_r - CNT_ONE;
                        counter_r     <= counter_r + 32'd1;
                        if (counter_r == 32'hffff_ffff) begin
                            ctr_wrap_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_engine.sv
// tb_chacha_block_engine - randomized scoreboard bench for chacha_block_engine.
// Expected blocks come from a whole-quarter-round reference of the ChaCha block
// function; a monitor pops them as the DUT hands blocks off.
module tb_chacha_block_engine;
    localparam int ROUNDS  = 20;
    localparam int LANES   = 1;
    localparam int COUNT_W = 8;
    localparam int LAT     = 2 + ROUNDS * 16 / LANES;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_valid = 1'b0;
    logic               start_ready;
    logic [255:0]       key = '0;
    logic [95:0]        nonce = '0;
    logic [31:0]        counter_init = '0;
    logic [COUNT_W-1:0] num_blocks = '0;
    logic               block_valid;
    logic               block_ready = 1'b0;
    logic [511:0]       block_out;
    logic [COUNT_W-1:0] block_count;
    logic               busy;
    logic               ctr_wrap;

    chacha_block_engine #(.ROUNDS(ROUNDS), .QR_LANES(LANES), .COUNT_W(COUNT_W)) u_dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .key(key), .nonce(nonce), .counter_init(counter_init),
`ifdef CHACHA_MULTIBLOCK_EN
        .num_blocks(num_blocks),
`endif
        .block_valid(block_valid), .block_ready(block_ready), .block_out(block_out),
        .block_count(block_count), .busy(busy), .ctr_wrap(ctr_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0]       blk;
        logic [COUNT_W-1:0] cnt;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           kick = 0;
    int           stall_target = 0;
    int           stall_cnt = 0;
    logic         prev_valid = 1'b0;
    logic [511:0] hold = '0;
    logic [511:0] last_blk = '0;
    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        a += b; d ^= a; d = rotl(d, 16);
        c += d; b ^= c; b = rotl(b, 12);
        a += b; d ^= a; d = rotl(d, 8);
        c += d; b ^= c; b = rotl(b, 7);
        return {a, b, c, d};
    endfunction

    // ChaCha block function: full quarter-rounds over columns then diagonals.
    function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] ctr);
        logic [31:0]  s[16];
        logic [31:0]  x[16];
        logic [511:0] res;
        logic [127:0] t;
        int dg[4][4] = '{'{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32 * i +: 32];
        x = s;
        for (int r = 0; r < ROUNDS / 2; r++) begin
            for (int q = 0; q < 4; q++) begin
                t = qr(x[q], x[q + 4], x[q + 8], x[q + 12]);
                x[q] = t[127:96]; x[q + 4] = t[95:64]; x[q + 8] = t[63:32]; x[q + 12] = t[31:0];
            end
            for (int q = 0; q < 4; q++) begin
                t = qr(x[dg[q][0]], x[dg[q][1]], x[dg[q][2]], x[dg[q][3]]);
                x[dg[q][0]] = t[127:96]; x[dg[q][1]] = t[95:64];
                x[dg[q][2]] = t[63:32];  x[dg[q][3]] = t[31:0];
            end
        end
        for (int i = 0; i < 16; i++) res[32 * i +: 32] = x[i] + s[i];
        return res;
    endfunction

    // Downstream ready: hold off stall_target cycles after block_valid, then accept.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                block_ready = 1'b0;
                stall_cnt   = 0;
            end else if (block_valid && !block_ready) begin
                if (stall_cnt >= stall_target) block_ready = 1'b1;
                else stall_cnt++;
            end else begin
                block_ready = 1'b0;
                stall_cnt   = 0;
            end
        end
    end

    // Monitor: latency, hold-while-stalled and scoreboard comparison at handoff.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (block_valid && !prev_valid) begin
                    chk("latency", 512'(cyc - kick), 512'(LAT));
                    hold = block_out;
                end else if (block_valid) begin
                    chk("hold_block_out", block_out, hold);
                    chk("hold_start_ready", 512'(start_ready), 512'(0));
                    chk("hold_busy", 512'(busy), 512'(1));
                end
                if (block_valid && block_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_block: actual %0h required no block", block_out);
                    end else begin
                        e = sb.pop_front();
                        chk("block_out", block_out, e.blk);
                        chk("block_count", 512'(block_count), 512'(e.cnt));
                        last_blk = block_out;
                        kick = cyc + 1;
                    end
                end
                prev_valid = block_valid;
            end
        end
    end

    task automatic start_req(input logic [255:0] k, input logic [95:0] n,
                             input logic [31:0] c, input int nb);
        int eff;
`ifdef CHACHA_MULTIBLOCK_EN
        eff = (nb == 0) ? 1 : nb;
`else
        eff = 1;
`endif
        for (int i = 0; i < eff; i++) begin
            exp_t e;
            e.blk = chacha_ref(k, n, c + 32'(i));
            e.cnt = COUNT_W'(i);
            sb.push_back(e);
        end
        @(negedge clk);
        key = k; nonce = n; counter_init = c; num_blocks = COUNT_W'(nb);
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        kick = cyc;
        start_valid = 1'b0;
        key = ~k; nonce = ~n; counter_init = ~c;
        chk("accept_busy", 512'(busy), 512'(1));
        chk("accept_wrap_clear", 512'(ctr_wrap), 512'(0));
        chk("accept_count_clear", 512'(block_count), 512'(0));
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            #4;
            if (start_ready && !block_valid && sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: actual busy with %0d pending, required idle", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
        return k;
    endfunction

    // Main stimulus sequence.
    initial begin
        for (int j = 0; j < 32; j++) rfc_key[8 * j +: 8] = 8'(j);
        rfc_nonce = {32'h0000_0000, 32'h4a00_0000, 32'h0900_0000};

        // Start asserted while reset is held: nothing may be accepted
        rst = 1'b1;
        start_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_start_ready", 512'(start_ready), 512'(1));
        chk("rst_block_valid", 512'(block_valid), 512'(0));
        chk("rst_block_out", block_out, 512'(0));
        chk("rst_block_count", 512'(block_count), 512'(0));
        chk("rst_ctr_wrap", 512'(ctr_wrap), 512'(0));
        start_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 512'(busy), 512'(0));

        // RFC 8439 2.3.2 test vector
        stall_target = 0;
        start_req(rfc_key, rfc_nonce, 32'd1, 1);
        wait_idle();
        chk("rfc_word0", 512'(last_blk[31:0]), 512'(32'he4e7f110));
        chk("rfc_word15", 512'(last_blk[511:480]), 512'(32'h4e3c50a2));
        chk("rfc_block_count", 512'(block_count), 512'(1));
        chk("rfc_ctr_wrap", 512'(ctr_wrap), 512'(0));

        // Random requests with random backpressure
        for (int t = 0; t < 5; t++) begin
            stall_target = $urandom_range(0, 3);
            start_req(rand_key(), {$urandom, $urandom, $urandom}, $urandom, $urandom_range(0, 3));
            wait_idle();
        end

        // Long backpressure
        stall_target = 10;
        start_req(rand_key(), {$urandom, $urandom, $urandom}, $urandom, 1);
        wait_idle();
        stall_target = 0;

        // Counter wrap
        start_req(rand_key(), {$urandom, $urandom, $urandom}, 32'hffff_ffff, 2);
        wait_idle();
        chk("wrap_ctr_wrap", 512'(ctr_wrap), 512'(1));
`ifdef CHACHA_MULTIBLOCK_EN
        chk("wrap_block_count", 512'(block_count), 512'(2));
`else
        chk("wrap_block_count", 512'(block_count), 512'(1));
`endif

        // Reset in the middle of a block
        start_req(rfc_key, rfc_nonce, 32'd1, 1);
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_block_valid", 512'(block_valid), 512'(0));
        chk("midrst_start_ready", 512'(start_ready), 512'(1));
        chk("midrst_block_count", 512'(block_count), 512'(0));
        chk("midrst_busy", 512'(busy), 512'(0));
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_req(rfc_key, rfc_nonce, 32'd1, 1);
        wait_idle();
        chk("post_rst_rfc_word0", 512'(last_blk[31:0]), 512'(32'he4e7f110));
        chk("post_rst_rfc_word15", 512'(last_blk[511:480]), 512'(32'h4e3c50a2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #600000;
        $display("FAIL watchdog: actual still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
